// File: rtl/multiboot_ctrl_if.sv
// ICAPE2 write port of the multiboot sequencer.
// The master drives the primitive; the slave side observes it.
interface multiboot_ctrl_if;
    logic        icap_csib;
    logic        icap_rdwrb;
    logic [31:0] icap_data;

    modport master (output icap_csib, output icap_rdwrb, output icap_data);
    modport slave  (input  icap_csib, input  icap_rdwrb, input  icap_data);
endinterface

// File: rtl/multiboot_ctrl.sv
// ICAPE2 multiboot sequencer: picks one of N_SLOTS flash images and issues the
// IPROG command sequence on a host request, a debounced button or an idle timeout.
module multiboot_ctrl #(
    parameter int          N_SLOTS         = 4,
    parameter logic [31:0] SLOT_BASE       = 32'h0000_0000,
    parameter logic [31:0] SLOT_STRIDE     = 32'h0020_0000,
    parameter int          BUTTON_SLOT     = 1,
    parameter int          DEFAULT_SLOT    = 1,
    parameter int          DEBOUNCE_CYCLES = 65536,
    parameter int          TIMEOUT_CYCLES  = 48000000,
    parameter int          WORD_GAP        = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             boot_button,
    input  logic             boot_req,
    input  logic [3:0]       slot_sel,
    input  logic             activity,
    input  logic             auto_en,
    multiboot_ctrl_if.master icap,
    output logic             busy,
    output logic [3:0]       active_slot,
    output logic             err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [31:0] DEB_LAST = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] GAP_LAST = 32'(WORD_GAP - 1);

    // ICAPE2 expects every byte bit-reversed relative to the bitstream order.
    function automatic logic [31:0] bit_swap(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++) begin
                r[8*k+j] = w[8*k+7-j];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] iprog_word(input logic [2:0] idx, input logic [31:0] wbstar);
        case (idx)
            3'd0:    return 32'hFFFF_FFFF;   // dummy
            3'd1:    return 32'hAA99_5566;   // sync
            3'd2:    return 32'h2000_0000;   // noop
            3'd3:    return 32'h3002_0001;   // write WBSTAR
            3'd4:    return wbstar;
            3'd5:    return 32'h3000_8001;   // write CMD
            3'd6:    return 32'h0000_000F;   // IPROG
            default: return 32'h2000_0000;   // noop
        endcase
    endfunction

    logic        btn_meta_q, btn_sync_q, btn_deb_q, btn_deb_d;
    logic [31:0] deb_cnt_q, deb_cnt_d;
    logic [31:0] timer_q, timer_d;
    logic [1:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] gap_q, gap_d;
    logic [31:0] wbstar_q, wbstar_d;
    logic [3:0]  slot_q, slot_d;
    logic        err_q, err_d;
    logic        csib_q, rdwrb_q, busy_q;
    logic [31:0] data_q;

    logic        deb_done, btn_trig, timer_clr, timeout_trig;
    logic        trig, err_set;
    logic [3:0]  trig_slot;
    logic [31:0] slot_addr;

    // Debounce: the level flips after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        deb_done  = (btn_sync_q != btn_deb_q) && (deb_cnt_q == DEB_LAST);
        btn_trig  = deb_done && btn_sync_q;
        btn_deb_d = deb_done ? btn_sync_q : btn_deb_q;
        deb_cnt_d = deb_cnt_q + 32'd1;
        if (btn_sync_q == btn_deb_q || deb_done) begin
            deb_cnt_d = 32'd0;
        end
    end

    always_comb begin
        timer_clr    = activity || !auto_en || (state_q != S_IDLE);
        timeout_trig = (TIMEOUT_CYCLES != 0) && !timer_clr && (timer_q == TMO_LAST);
        timer_d      = (timer_clr || timeout_trig) ? 32'd0 : timer_q + 32'd1;
    end

    // A host request always wins, even an out-of-range one that only flags err.
    always_comb begin
        trig      = 1'b0;
        err_set   = 1'b0;
        trig_slot = 4'd0;
        if (state_q == S_IDLE) begin
            if (boot_req) begin
                if ({1'b0, slot_sel} < 5'(N_SLOTS)) begin
                    trig      = 1'b1;
                    trig_slot = slot_sel;
                end else begin
                    err_set = 1'b1;
                end
            end else if (btn_trig) begin
                trig      = 1'b1;
                trig_slot = 4'(BUTTON_SLOT);
            end else if (timeout_trig) begin
                trig      = 1'b1;
                trig_slot = 4'(DEFAULT_SLOT);
            end
        end
        slot_addr = SLOT_BASE + SLOT_STRIDE * {28'd0, trig_slot};
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        wbstar_d = wbstar_q;
        slot_d   = slot_q;
        err_d    = err_q || err_set;
        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_d  = S_SEND;
                    idx_d    = 3'd0;
                    wbstar_d = {3'b000, slot_addr[28:0]};
                    slot_d   = trig_slot;
                end
            end
            S_SEND: begin
                if (idx_q == 3'd7) begin
                    state_d = S_DONE;
                end else if (WORD_GAP > 0) begin
                    state_d = S_GAP;
                    gap_d   = 32'd0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_SEND;
                    idx_d   = idx_q + 3'd1;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            default: state_d = S_DONE;   // the FPGA reconfigures; only reset leaves DONE
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_deb_q  <= 1'b0;
            deb_cnt_q  <= 32'd0;
            timer_q    <= 32'd0;
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            gap_q      <= 32'd0;
            wbstar_q   <= 32'd0;
            slot_q     <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            btn_meta_q <= boot_button;
            btn_sync_q <= btn_meta_q;
            btn_deb_q  <= btn_deb_d;
            deb_cnt_q  <= deb_cnt_d;
            timer_q    <= timer_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            wbstar_q   <= wbstar_d;
            slot_q     <= slot_d;
            err_q      <= err_d;
        end
    end

    // ICAP outputs are registered from the state, one cycle behind the trigger edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csib_q  <= 1'b1;
            rdwrb_q <= 1'b1;
            busy_q  <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            csib_q  <= (state_q != S_SEND);
            rdwrb_q <= !(state_q == S_SEND || state_q == S_GAP);
            busy_q  <= (state_q != S_IDLE);
            if (state_q == S_SEND) begin
                data_q <= bit_swap(iprog_word(idx_q, wbstar_q));
            end
        end
    end

    assign icap.icap_csib  = csib_q;
    assign icap.icap_rdwrb = rdwrb_q;
    assign icap.icap_data  = data_q;
    assign busy            = busy_q;
    assign active_slot     = slot_q;
    assign err             = err_q;

endmodule

// File: tb/tb_multiboot_ctrl.sv
// Directed bench for multiboot_ctrl: three instances cover default, short
// timeout/debounce, and inter-word gap configurations.
module tb_multiboot_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, rst_c;
    logic       boot_button, boot_req, activity, auto_en;
    logic [3:0] slot_sel;

    multiboot_ctrl_if if_a ();
    multiboot_ctrl_if if_b ();
    multiboot_ctrl_if if_c ();

    logic       busy_a, busy_b, busy_c, err_a, err_b, err_c;
    logic [3:0] slot_a, slot_b, slot_c;

    multiboot_ctrl u_a (
        .clk(clk), .reset(rst_a), .boot_button(boot_button), .boot_req(boot_req),
        .slot_sel(slot_sel), .activity(activity), .auto_en(auto_en), .icap(if_a),
        .busy(busy_a), .active_slot(slot_a), .err(err_a));

    multiboot_ctrl #(.TIMEOUT_CYCLES(100), .DEBOUNCE_CYCLES(64)) u_b (
        .clk(clk), .reset(rst_b), .boot_button(boot_button), .boot_req(boot_req),
        .slot_sel(slot_sel), .activity(activity), .auto_en(auto_en), .icap(if_b),
        .busy(busy_b), .active_slot(slot_b), .err(err_b));

    multiboot_ctrl #(.WORD_GAP(2)) u_c (
        .clk(clk), .reset(rst_c), .boot_button(boot_button), .boot_req(boot_req),
        .slot_sel(slot_sel), .activity(activity), .auto_en(auto_en), .icap(if_c),
        .busy(busy_c), .active_slot(slot_c), .err(err_c));

    int          dut_sel = 0;
    logic        obs_csib, obs_rdwrb, obs_busy, obs_err;
    logic [31:0] obs_data;
    logic [3:0]  obs_slot;

    always_comb begin
        obs_csib = if_a.icap_csib; obs_rdwrb = if_a.icap_rdwrb; obs_data = if_a.icap_data;
        obs_busy = busy_a; obs_slot = slot_a; obs_err = err_a;
        if (dut_sel == 1) begin
            obs_csib = if_b.icap_csib; obs_rdwrb = if_b.icap_rdwrb; obs_data = if_b.icap_data;
            obs_busy = busy_b; obs_slot = slot_b; obs_err = err_b;
        end else if (dut_sel == 2) begin
            obs_csib = if_c.icap_csib; obs_rdwrb = if_c.icap_rdwrb; obs_data = if_c.icap_data;
            obs_busy = busy_c; obs_slot = slot_c; obs_err = err_c;
        end
    end

    int errors = 0;
    int checks = 0;

    // Bit-swapped IPROG words as they must appear on icap_data; index 4 is WBSTAR.
    logic [31:0] seq_words [8];

    function automatic logic [31:0] exp_word(input int i, input logic [31:0] wb_swapped);
        return (i == 4) ? wb_swapped : seq_words[i];
    endfunction

    // Holds every instance in reset, then releases only the selected one on a falling edge.
    task automatic reset_dut(input int sel, input logic auto);
        dut_sel     = sel;
        boot_button = 1'b0;
        boot_req    = 1'b0;
        activity    = 1'b0;
        slot_sel    = 4'd0;
        auto_en     = auto;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = (sel == 0); rst_b = (sel == 1); rst_c = (sel == 2);
    endtask

    task automatic test_reset;
        reset_dut(0, 1'b0);
        checks++;
        if ({obs_csib, obs_rdwrb, obs_busy, obs_err} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_ctrl: csib/rdwrb/busy/err=%b expected 1100", {obs_csib, obs_rdwrb, obs_busy, obs_err});
        end
        checks++;
        if (obs_data !== 32'h0 || obs_slot !== 4'd0) begin
            errors++;
            $display("FAIL reset_data: data=%h slot=%0d expected 00000000/0", obs_data, obs_slot);
        end
    endtask

    task automatic test_boot_req;
        boot_req = 1'b1; slot_sel = 4'd2;
        @(negedge clk);
        boot_req = 1'b0;
        checks++;
        if (obs_slot !== 4'd2 || obs_csib !== 1'b1) begin
            errors++;
            $display("FAIL req_latch: slot=%0d csib=%b expected 2/1", obs_slot, obs_csib);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({obs_csib, obs_rdwrb, obs_busy} !== 3'b001 || obs_data !== exp_word(i, 32'h0002_0000)) begin
                errors++;
                $display("FAIL req_word%0d: ctl=%b data=%h expected 001/%h", i,
                         {obs_csib, obs_rdwrb, obs_busy}, obs_data, exp_word(i, 32'h0002_0000));
            end
        end
        @(negedge clk);
        checks++;
        if ({obs_csib, obs_rdwrb, obs_busy} !== 3'b111) begin
            errors++;
            $display("FAIL req_done: ctl=%b expected 111", {obs_csib, obs_rdwrb, obs_busy});
        end
        boot_req = 1'b1; slot_sel = 4'd0;
        @(negedge clk);
        boot_req = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (obs_slot !== 4'd2 || obs_csib !== 1'b1 || obs_busy !== 1'b1) begin
            errors++;
            $display("FAIL req_in_done: slot=%0d csib=%b busy=%b expected 2/1/1", obs_slot, obs_csib, obs_busy);
        end
    endtask

    task automatic test_bad_slot;
        logic any_low;
        reset_dut(0, 1'b0);
        boot_req = 1'b1; slot_sel = 4'd4;
        @(negedge clk);
        boot_req = 1'b0;
        any_low = 1'b0;
        repeat (10) begin @(negedge clk); any_low |= !obs_csib; end
        checks++;
        if ({obs_err, obs_busy, any_low} !== 3'b100 || obs_slot !== 4'd0) begin
            errors++;
            $display("FAIL bad_slot4: err/busy/anylow=%b slot=%0d expected 100/0", {obs_err, obs_busy, any_low}, obs_slot);
        end
        reset_dut(0, 1'b0);
        checks++;
        if (obs_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b expected 0", obs_err);
        end
        boot_req = 1'b1; slot_sel = 4'd5;
        @(negedge clk);
        boot_req = 1'b0;
        any_low = 1'b0;
        repeat (5) begin @(negedge clk); any_low |= !obs_csib; end
        checks++;
        if ({obs_err, obs_busy, any_low} !== 3'b100) begin
            errors++;
            $display("FAIL bad_slot5: err/busy/anylow=%b expected 100", {obs_err, obs_busy, any_low});
        end
        boot_req = 1'b1; slot_sel = 4'd0;
        @(negedge clk);
        boot_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (obs_csib !== 1'b0 || obs_data !== exp_word(i, 32'h0) || obs_err !== 1'b1) begin
                errors++;
                $display("FAIL after_bad_word%0d: csib=%b data=%h err=%b expected 0/%h/1", i,
                         obs_csib, obs_data, obs_err, exp_word(i, 32'h0));
            end
        end
    endtask

    task automatic test_timeout;
        int first;
        reset_dut(1, 1'b1);
        first = 0;
        for (int k = 1; k <= 300 && first == 0; k++) begin
            activity = (k == 50);
            @(negedge clk);
            if (!obs_csib) first = k;
        end
        activity = 1'b0;
        checks++;
        if (first !== 151) begin
            errors++;
            $display("FAIL timeout_edge: first csib low after edge %0d expected 151", first);
        end
        checks++;
        if (obs_data !== 32'hFFFF_FFFF || obs_slot !== 4'd1) begin
            errors++;
            $display("FAIL timeout_first: data=%h slot=%0d expected ffffffff/1", obs_data, obs_slot);
        end
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (obs_csib !== 1'b0 || obs_data !== exp_word(i, 32'h0004_0000)) begin
                errors++;
                $display("FAIL timeout_word%0d: csib=%b data=%h expected 0/%h", i, obs_csib, obs_data, exp_word(i, 32'h0004_0000));
            end
        end
    endtask

    task automatic test_button;
        logic any_low;
        int   first, n_low;
        reset_dut(1, 1'b0);
        any_low = 1'b0;
        repeat (4) begin
            boot_button = 1'b1;
            repeat (10) begin @(negedge clk); any_low |= !obs_csib; end
            boot_button = 1'b0;
            repeat (10) begin @(negedge clk); any_low |= !obs_csib; end
        end
        checks++;
        if (any_low !== 1'b0 || obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL button_bounce: anylow=%b busy=%b expected 0/0", any_low, obs_busy);
        end
        boot_button = 1'b1;
        first = 0;
        for (int k = 1; k <= 200 && first == 0; k++) begin
            @(negedge clk);
            if (!obs_csib) first = k;
        end
        checks++;
        if (first !== 67 || obs_slot !== 4'd1) begin
            errors++;
            $display("FAIL button_edge: first low at %0d slot=%0d expected 67/1", first, obs_slot);
        end
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (obs_csib !== 1'b0 || obs_data !== exp_word(i, 32'h0004_0000)) begin
                errors++;
                $display("FAIL button_word%0d: csib=%b data=%h expected 0/%h", i, obs_csib, obs_data, exp_word(i, 32'h0004_0000));
            end
        end
        n_low = 0;
        repeat (20) begin @(negedge clk); n_low += int'(!obs_csib); end
        boot_button = 1'b0;
        checks++;
        if (n_low !== 0 || obs_busy !== 1'b1) begin
            errors++;
            $display("FAIL button_once: extra low cycles=%0d busy=%b expected 0/1", n_low, obs_busy);
        end
    endtask

    task automatic test_priority;
        int first, n_low;
        reset_dut(1, 1'b1);
        first = 0;
        slot_sel = 4'd3;
        for (int k = 1; k <= 300 && first == 0; k++) begin
            boot_button = (k >= 35);
            boot_req    = (k == 100);
            @(negedge clk);
            if (!obs_csib) first = k;
        end
        boot_req = 1'b0;
        checks++;
        if (first !== 101 || obs_slot !== 4'd3) begin
            errors++;
            $display("FAIL prio_edge: first low at %0d slot=%0d expected 101/3", first, obs_slot);
        end
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (obs_csib !== 1'b0 || obs_data !== exp_word(i, 32'h0006_0000)) begin
                errors++;
                $display("FAIL prio_word%0d: csib=%b data=%h expected 0/%h", i, obs_csib, obs_data, exp_word(i, 32'h0006_0000));
            end
        end
        n_low = 0;
        repeat (20) begin @(negedge clk); n_low += int'(!obs_csib); end
        boot_button = 1'b0;
        checks++;
        if (n_low !== 0) begin
            errors++;
            $display("FAIL prio_once: extra low cycles=%0d expected 0", n_low);
        end
    endtask

    task automatic test_gap_reset;
        logic any_low;
        int   idx;
        reset_dut(2, 1'b0);
        boot_req = 1'b1; slot_sel = 4'd2;
        @(negedge clk);
        boot_req = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            idx = (c - 1) / 3;
            checks++;
            if (obs_csib !== ((c - 1) % 3 != 0) || obs_rdwrb !== 1'b0 || obs_busy !== 1'b1 ||
                obs_data !== exp_word(idx, 32'h0002_0000)) begin
                errors++;
                $display("FAIL gap_cycle%0d: csib=%b rdwrb=%b busy=%b data=%h expected %b/0/1/%h", c,
                         obs_csib, obs_rdwrb, obs_busy, obs_data, ((c - 1) % 3 != 0), exp_word(idx, 32'h0002_0000));
            end
        end
        #2 rst_c = 1'b0;
        #1;
        checks++;
        if ({obs_csib, obs_rdwrb, obs_busy} !== 3'b110 || obs_data !== 32'h0) begin
            errors++;
            $display("FAIL gap_async_reset: ctl=%b data=%h expected 110/00000000", {obs_csib, obs_rdwrb, obs_busy}, obs_data);
        end
        repeat (2) @(negedge clk);
        rst_c = 1'b1;
        any_low = 1'b0;
        repeat (20) begin @(negedge clk); any_low |= !obs_csib; end
        checks++;
        if (any_low !== 1'b0 || obs_busy !== 1'b0 || obs_rdwrb !== 1'b1) begin
            errors++;
            $display("FAIL gap_abandon: anylow=%b busy=%b rdwrb=%b expected 0/0/1", any_low, obs_busy, obs_rdwrb);
        end
    endtask

    initial begin
        seq_words[0] = 32'hFFFF_FFFF;
        seq_words[1] = 32'h5599_AA66;
        seq_words[2] = 32'h0400_0000;
        seq_words[3] = 32'h0C40_0080;
        seq_words[4] = 32'h0000_0000;
        seq_words[5] = 32'h0C00_0180;
        seq_words[6] = 32'h0000_00F0;
        seq_words[7] = 32'h0400_0000;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        boot_button = 1'b0; boot_req = 1'b0; activity = 1'b0; auto_en = 1'b0; slot_sel = 4'd0;

        test_reset;
        test_boot_req;
        test_bad_slot;
        test_timeout;
        test_button;
        test_priority;
        test_gap_reset;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
